// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: ALU op encodings, instruction field positions, sequencer states.
package cgra_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_LT  = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam int OP_LSB  = 12;
  localparam int OP_MSB  = 14;
  localparam int END_BIT = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctx_state_t;

  function automatic logic [2:0] instr_op(input logic [31:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/cgra_ctx_mem.sv
// Context store: DEPTH x 32 register file, one synchronous write port, one combinational read port.
module cgra_ctx_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Contents survive reset; validity is tracked by the sequencer's write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cgra_ctx_sequencer.sv
// Per-PE context sequencer: loads instruction words over valid/ready, then replays them
// (optionally looped) one per cycle onto the ALU instruction interface.
module cgra_ctx_sequencer
  import cgra_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [31:0]   cfg_data,
  input  logic          cfg_clear,
  input  logic          start,
  input  logic [LW-1:0] loops,
  input  logic          stall,
  input  logic          abort,
  output logic [31:0]   instr,
  output logic          alu_en,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   ctx_count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  ctx_state_t    state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [LW-1:0] pass_q, pass_d;
  logic [LW-1:0] loops_q, loops_d;
  logic [31:0]   instr_q, instr_d;
  logic          alu_en_q, alu_en_d;
  logic          done_q, done_d;

  logic [AW:0]   cnt_next;
  logic          mem_we;
  logic [31:0]   rd_data;
  logic          wrap;
  logic          load;

  cgra_ctx_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (cfg_data),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  assign cfg_ready = !rst && (state_q == ST_IDLE) && (wr_ptr_q < DEPTH_C);
  assign load      = cfg_valid && cfg_ready;
  assign wrap      = ({1'b0, pc_q} == (wr_ptr_q - 1'b1)) || rd_data[END_BIT];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    pc_d     = pc_q;
    pass_d   = pass_q;
    loops_d  = loops_q;
    instr_d  = instr_q;
    alu_en_d = alu_en_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    cnt_next = wr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        instr_d  = '0;
        alu_en_d = 1'b0;
        // alu_en still high while idle only happens right after the final issue.
        done_d   = alu_en_q;
        if (cfg_clear) begin
          cnt_next = '0;
        end else if (load) begin
          mem_we   = 1'b1;
          cnt_next = wr_ptr_q + 1'b1;
        end
        wr_ptr_d = cnt_next;
        if (start && (cnt_next != '0)) begin
          state_d = ST_RUN;
          pc_d    = '0;
          pass_d  = '0;
          loops_d = loops;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          alu_en_d = 1'b0;
          instr_d  = '0;
        end else if (!stall) begin
          instr_d  = rd_data;
          alu_en_d = 1'b1;
          if (wrap) begin
            pc_d = '0;
            if (pass_q == loops_q) begin
              state_d = ST_IDLE;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      pc_q     <= '0;
      pass_q   <= '0;
      loops_q  <= '0;
      instr_q  <= '0;
      alu_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      pc_q     <= pc_d;
      pass_q   <= pass_d;
      loops_q  <= loops_d;
      instr_q  <= instr_d;
      alu_en_q <= alu_en_d;
      done_q   <= done_d;
    end
  end

  assign instr     = instr_q;
  assign alu_en    = alu_en_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_RUN);
  assign ctx_count = wr_ptr_q;

endmodule

// File: tb/tb_cgra_ctx_sequencer.sv
// Directed bench for cgra_ctx_sequencer: load, replay, looping, END marker, full, stall, abort, reset.
module tb_cgra_ctx_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   cfg_data;
  logic          cfg_clear;
  logic          start;
  logic [LW-1:0] loops;
  logic          stall;
  logic          abort;
  logic [31:0]   instr;
  logic          alu_en;
  logic          busy;
  logic          done;
  logic [AW:0]   ctx_count;

  int errors = 0;
  int checks = 0;

  cgra_ctx_sequencer #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_clear (cfg_clear),
    .start     (start),
    .loops     (loops),
    .stall     (stall),
    .abort     (abort),
    .instr     (instr),
    .alu_en    (alu_en),
    .busy      (busy),
    .done      (done),
    .ctx_count (ctx_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int op, input bit e, input int tag);
    logic [31:0] w;
    w        = 32'h0;
    w[31]    = e;
    w[14:12] = op[2:0];
    w[7:0]   = tag[7:0];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    cfg_valid = 1'b1;
    cfg_data  = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic clear_ctx();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  task automatic kick(input int n_loops);
    loops = n_loops[LW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (alu_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_en_done got %b%b want 00", alu_en, done); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
    checks++; if (ctx_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", ctx_count); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_load_replay();
    int exp_en[5]   = '{1, 1, 1, 0, 0};
    int exp_op[5]   = '{0, 1, 7, 0, 0};
    int exp_done[5] = '{0, 0, 0, 1, 0};
    int exp_busy[5] = '{1, 1, 0, 0, 0};
    load_word(mk(0, 0, 0));
    load_word(mk(1, 0, 1));
    load_word(mk(7, 0, 2));
    checks++; if (ctx_count !== 5'd3) begin errors++; $display("FAIL lr_count got %0d want 3", ctx_count); end
    kick(0);
    checks++; if (busy !== 1'b1 || alu_en !== 1'b0) begin errors++; $display("FAIL lr_startedge busy/en got %b%b want 10", busy, alu_en); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (alu_en !== exp_en[k][0] || done !== exp_done[k][0] || busy !== exp_busy[k][0]) begin
        errors++;
        $display("FAIL lr_ctrl k=%0d got en/done/busy %b%b%b want %0d%0d%0d", k+1, alu_en, done, busy, exp_en[k], exp_done[k], exp_busy[k]);
      end
      if (exp_en[k] == 1) begin
        checks++;
        if (instr[14:12] !== exp_op[k][2:0]) begin errors++; $display("FAIL lr_op k=%0d got %0d want %0d", k+1, instr[14:12], exp_op[k]); end
      end
    end
  endtask

  task automatic test_loop_end();
    int exp_op[6] = '{2, 3, 2, 3, 2, 3};
    int n_iss = 0;
    int n_done = 0;
    clear_ctx();
    load_word(mk(2, 0, 0));
    load_word(mk(3, 1, 1));
    load_word(mk(4, 0, 2));
    load_word(mk(5, 0, 3));
    kick(2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (alu_en) n_iss++;
      if (done) begin
        n_done++;
        checks++; if (k !== 7) begin errors++; $display("FAIL le_done_pos got %0d want 7", k); end
      end
      if (k <= 6) begin
        checks++;
        if (alu_en !== 1'b1 || instr[14:12] !== exp_op[k-1][2:0]) begin
          errors++; $display("FAIL le_op k=%0d got en=%b op=%0d want en=1 op=%0d", k, alu_en, instr[14:12], exp_op[k-1]);
        end
      end
    end
    checks++; if (n_iss !== 6) begin errors++; $display("FAIL le_issues got %0d want 6", n_iss); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL le_dones got %0d want 1", n_done); end
  endtask

  task automatic test_full();
    clear_ctx();
    cfg_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cfg_data = mk(i % 8, 0, i);
      tick();
    end
    cfg_valid = 1'b0;
    checks++; if (ctx_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", ctx_count); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", cfg_ready); end
    kick(0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 16) begin
        checks++;
        if (alu_en !== 1'b1 || instr[7:0] !== k[7:0] - 8'd1) begin
          errors++; $display("FAIL full_replay k=%0d got en=%b tag=%0d want en=1 tag=%0d", k, alu_en, instr[7:0], k-1);
        end
      end else begin
        checks++; if (done !== 1'b1 || alu_en !== 1'b0) begin errors++; $display("FAIL full_done got done/en %b%b want 10", done, alu_en); end
      end
    end
    cfg_valid = 1'b1;
    cfg_data  = mk(0, 0, 16);
    tick(); tick();
    checks++; if (ctx_count !== 5'd16 || cfg_ready !== 1'b0) begin errors++; $display("FAIL full_pending got count=%0d ready=%b want 16 0", ctx_count, cfg_ready); end
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    checks++; if (ctx_count !== 5'd0) begin errors++; $display("FAIL full_clear got %0d want 0", ctx_count); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL full_clear_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_stall();
    int exp_op[7] = '{1, 2, 2, 2, 2, 3, 4};
    int n_en = 0;
    clear_ctx();
    for (int i = 0; i < 4; i++) load_word(mk(i + 1, 0, i));
    kick(0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (alu_en) n_en++;
      if (k <= 7) begin
        checks++;
        if (alu_en !== 1'b1 || instr[14:12] !== exp_op[k-1][2:0]) begin
          errors++; $display("FAIL st_op k=%0d got en=%b op=%0d want en=1 op=%0d", k, alu_en, instr[14:12], exp_op[k-1]);
        end
      end else if (k == 8) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL st_done got %b want 1", done); end
      end
      if (k == 2) stall = 1'b1;
      if (k == 5) stall = 1'b0;
    end
    checks++; if (n_en !== 7) begin errors++; $display("FAIL st_length got %0d want 7", n_en); end
  endtask

  task automatic test_abort();
    clear_ctx();
    load_word(mk(5, 0, 0));
    load_word(mk(6, 0, 1));
    load_word(mk(7, 0, 2));
    load_word(mk(0, 0, 3));
    kick(0);
    tick();
    tick();
    checks++; if (instr[14:12] !== 3'd6 || alu_en !== 1'b1) begin errors++; $display("FAIL ab_second got op=%0d en=%b want 6 1", instr[14:12], alu_en); end
    abort = 1'b1;
    stall = 1'b1;
    tick();
    abort = 1'b0;
    stall = 1'b0;
    checks++; if (alu_en !== 1'b0 || busy !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL ab_stop got en=%b busy=%b instr=%h want 0 0 0", alu_en, busy, instr); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_nodone1 got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_nodone2 got %b want 0", done); end

    kick(0);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (instr[14:12] !== 3'd7 || busy !== 1'b1) begin errors++; $display("FAIL ab_restart got op=%0d busy=%b want 7 1", instr[14:12], busy); end
    tick();
    checks++; if (instr[14:12] !== 3'd0 || alu_en !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ab_last got op=%0d en=%b busy=%b want 0 1 0", instr[14:12], alu_en, busy); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ab_run_done got %b want 1", done); end

    clear_ctx();
    start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_empty_busy got %b want 0", busy); end
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || alu_en !== 1'b0) begin errors++; $display("FAIL ab_empty got busy/done/en %b%b%b want 000", busy, done, alu_en); end
  endtask

  task automatic test_max_loops();
    int n_iss = 0;
    int n_done = 0;
    int done_k = -1;
    load_word(mk(3, 0, 9));
    kick(255);
    for (int k = 1; k <= 270; k++) begin
      tick();
      if (alu_en) n_iss++;
      if (done) begin n_done++; done_k = k; end
    end
    checks++; if (n_iss !== 256) begin errors++; $display("FAIL ml_issues got %0d want 256", n_iss); end
    checks++; if (n_done !== 1 || done_k !== 257) begin errors++; $display("FAIL ml_done got n=%0d at=%0d want 1 at 257", n_done, done_k); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ml_timeout busy got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    clear_ctx();
    load_word(mk(1, 0, 0));
    load_word(mk(2, 0, 1));
    load_word(mk(3, 0, 2));
    kick(3);
    tick();
    tick();
    checks++; if (alu_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_running got en/busy %b%b want 11", alu_en, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (alu_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ar_drop got en/busy/done %b%b%b want 000", alu_en, busy, done); end
    checks++; if (ctx_count !== 5'd0 || cfg_ready !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL ar_state got count=%0d ready=%b instr=%h want 0 0 0", ctx_count, cfg_ready, instr); end
    #2 rst = 1'b0;
    tick();
    checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || alu_en !== 1'b0) begin errors++; $display("FAIL ar_after got ready/busy/en %b%b%b want 100", cfg_ready, busy, alu_en); end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 32'h0;
    cfg_clear = 1'b0;
    start     = 1'b0;
    loops     = '0;
    stall     = 1'b0;
    abort     = 1'b0;
    test_reset();
    test_load_replay();
    test_loop_end();
    test_full();
    test_stall();
    test_abort();
    test_max_loops();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
